// File: rtl/avl_burst_arbiter_if.sv
// Avalon-style burst bus bundle shared by requesters and the slave port.
// master modport: drives command/write data, receives ready and read responses.
// slave modport : receives command/write data, drives ready and read responses.
interface avl_burst_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BCW = 8;
  localparam int unsigned BEW = 4;

  logic [AW-1:0]  address;
  logic           read;
  logic           write;
  logic           begin_burst_transfer;
  logic [BCW-1:0] burst_count;
  logic [BEW-1:0] byte_en;
  logic [DW-1:0]  write_data;
  logic           request_ready;
  logic [DW-1:0]  read_data;
  logic           resp_valid;

  modport master (
    output address, read, write, begin_burst_transfer, burst_count, byte_en, write_data,
    input  request_ready, read_data, resp_valid
  );

  modport slave (
    input  address, read, write, begin_burst_transfer, burst_count, byte_en, write_data,
    output request_ready, read_data, resp_valid
  );
endinterface

// File: rtl/avl_burst_arbiter.sv
// Two-requester Avalon burst arbiter with read-credit flow control.
// Ports:
//   clk, rest_n : clock and asynchronous active-low reset
//   m0, m1      : requester buses (slave modport of avl_burst_arbiter_if)
//   s           : downstream slave bus (master modport)
//   grant       : one-hot current owner, 2'b00 when idle (debug)
// Build option: define AVL_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise m0 has fixed priority.
module avl_burst_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 256
) (
  input  logic                 clk,
  input  logic                 rest_n,
  avl_burst_arbiter_if.slave   m0,
  avl_burst_arbiter_if.slave   m1,
  avl_burst_arbiter_if.master  s,
  output logic [1:0]           grant
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BCW = 8;
  localparam int unsigned BTW = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [1:0]     pend;
  logic [BCW-1:0] pcount [2];
  logic [1:0]     pread;
  logic           owner;
  logic           last_winner;
  logic           cur_read;
  logic [BCW-1:0] cur_count;
  logic [BTW-1:0] beat_cnt;
  logic [BTW-1:0] resp_rem;
  logic [CW-1:0]  credit;

  logic [1:0]     bhit;
  logic [BCW-1:0] bcount_in [2];
  logic [1:0]     bread_in;
  logic [BTW-1:0] need [2];
  logic [1:0]     elig;
  logic           win;
  logic           take;
  logic [BTW-1:0] last_beat;
  logic           xfer_open;
  logic           beat_inc;
  logic           rd_beat;

  // Begin pulses qualified by a valid direction
  assign bhit[0]      = m0.begin_burst_transfer && (m0.read || m0.write);
  assign bhit[1]      = m1.begin_burst_transfer && (m1.read || m1.write);
  assign bcount_in[0] = m0.burst_count;
  assign bcount_in[1] = m1.burst_count;
  assign bread_in[0]  = m0.read;
  assign bread_in[1]  = m1.read;

  // Beats per pending burst; a read only competes when credit covers the whole burst
  assign need[0] = BTW'(pcount[0]) + BTW'(1);
  assign need[1] = BTW'(pcount[1]) + BTW'(1);
  assign elig[0] = pend[0] && (!pread[0] || (32'(credit) >= 32'(need[0])));
  assign elig[1] = pend[1] && (!pread[1] || (32'(credit) >= 32'(need[1])));

  // Winner selection among eligible requesters
`ifdef AVL_ARB_ROUND_ROBIN_EN
  assign win = (elig == 2'b11) ? ~last_winner : ~elig[0];
`else
  assign win = ~elig[0];
`endif

  assign take = (state == IDLE) && (|elig);

  // Beat window stays open until beat_cnt reaches burst_count+1 (9-bit, no wrap)
  assign last_beat = BTW'(cur_count) + BTW'(1);
  assign xfer_open = ((state == ISSUE) || (state == BURST)) && (beat_cnt != last_beat);
  assign beat_inc  = xfer_open && s.request_ready;
  assign rd_beat   = beat_inc && cur_read;

  // State register
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = BURST;
      BURST:   if (!xfer_open) state_nxt = cur_read ? DRAIN : IDLE;
      DRAIN:   if (resp_rem == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending requests, ownership, beat/response counters and read credit
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      pend        <= '0;
      pcount[0]   <= '0;
      pcount[1]   <= '0;
      pread       <= '0;
      grant       <= '0;
      owner       <= 1'b0;
      last_winner <= 1'b1;
      cur_read    <= 1'b0;
      cur_count   <= '0;
      beat_cnt    <= '0;
      resp_rem    <= '0;
      credit      <= CW'(MAX_OUTSTANDING);
    end else begin
      for (int n = 0; n < 2; n++) begin
        // Grant clears the request; a pulse while still pending is dropped
        if (take && (win == 1'(n))) begin
          pend[n] <= 1'b0;
        end else if (bhit[n] && !pend[n]) begin
          pend[n]   <= 1'b1;
          pcount[n] <= bcount_in[n];
          pread[n]  <= bread_in[n];
        end
      end

      if (take) begin
        grant       <= win ? 2'b10 : 2'b01;
        owner       <= win;
        last_winner <= win;
        cur_count   <= pcount[win];
        cur_read    <= pread[win];
        beat_cnt    <= '0;
        resp_rem    <= pread[win] ? need[win] : '0;
      end else begin
        if (beat_inc) beat_cnt <= beat_cnt + BTW'(1);
        if (s.resp_valid && (resp_rem != '0)) resp_rem <= resp_rem - BTW'(1);
        if ((state != IDLE) && (state_nxt == IDLE)) grant <= '0;
      end

      credit <= credit - CW'(rd_beat) + CW'(s.resp_valid);
    end
  end

  // Bus muxing toward the slave and response routing back to the read owner
  always_comb begin
    s.address              = '0;
    s.read                 = 1'b0;
    s.write                = 1'b0;
    s.begin_burst_transfer = (state == ISSUE);
    s.burst_count          = (state == ISSUE) ? cur_count : '0;
    s.byte_en              = '0;
    s.write_data           = '0;
    m0.request_ready       = 1'b0;
    m0.read_data           = '0;
    m0.resp_valid          = 1'b0;
    m1.request_ready       = 1'b0;
    m1.read_data           = '0;
    m1.resp_valid          = 1'b0;

    if (xfer_open) begin
      if (!owner) begin
        s.address        = m0.address;
        s.read           = m0.read;
        s.write          = m0.write;
        s.byte_en        = m0.byte_en;
        s.write_data     = m0.write_data;
        m0.request_ready = s.request_ready;
      end else begin
        s.address        = m1.address;
        s.read           = m1.read;
        s.write          = m1.write;
        s.byte_en        = m1.byte_en;
        s.write_data     = m1.write_data;
        m1.request_ready = s.request_ready;
      end
    end

    if ((state != IDLE) && cur_read) begin
      if (!owner) begin
        m0.resp_valid = s.resp_valid;
        m0.read_data  = s.read_data;
      end else begin
        m1.resp_valid = s.resp_valid;
        m1.read_data  = s.read_data;
      end
    end
  end

endmodule

// File: tb/tb_avl_burst_arbiter.sv
// Self-checking bench for avl_burst_arbiter: bus-functional masters and slave,
// per-requester expectation queues filled when bursts are launched.
module tb_avl_burst_arbiter;

  logic       clk = 1'b0;
  logic       rest_n;
  logic [1:0] grant;

  avl_burst_arbiter_if mi0 ();
  avl_burst_arbiter_if mi1 ();
  avl_burst_arbiter_if si ();

  avl_burst_arbiter dut (
    .clk    (clk),
    .rest_n (rest_n),
    .m0     (mi0),
    .m1     (mi1),
    .s      (si),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  typedef struct { bit rd; logic [31:0] base; int cnt; int pulses; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wexp_t;
  typedef struct { int due; logic [31:0] addr; } rsp_t;

  int nchk = 0;
  int nfail = 0;

  // Requests from the main sequence to the masters
  req_t req [2];
  int   req_seq [2];
  int   abort_seq = 0;
  bit   tog = 1'b0;

  // Bus-model state
  int    cyc = 0;
  bit    act [2];
  int    beat [2];
  int    pulse [2];
  int    taken [2];
  int    seen [2];
  req_t  cur [2];
  int    abort_taken = 0;
  int    pulse_cyc [2];
  wexp_t wq0 [$];
  wexp_t wq1 [$];
  logic [31:0] rq0 [$];
  logic [31:0] rq1 [$];
  rsp_t  rsp [$];

  // Observation counters (monotonic)
  int acc [2];
  int gcyc [2];
  int rcnt [2];
  int nbegin = 0;
  int last_begin_cyc = 0;
  logic [7:0] last_bc;
  logic [1:0] glog [$];
  int bcyc [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input int n, input logic [31:0] base, input int b);
    return base ^ {8'(n + 1), 8'(b), 16'hC0DE};
  endfunction

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Sample DUT outputs mid-cycle and pop expectations
  task automatic monitor();
    wexp_t e;
    logic [31:0] r;
    int who;
    if (si.begin_burst_transfer) begin
      nbegin++;
      last_begin_cyc = cyc;
      last_bc = si.burst_count;
      glog.push_back(grant);
      bcyc.push_back(cyc);
    end
    if (grant == 2'b01) gcyc[0]++;
    if (grant == 2'b10) gcyc[1]++;
    if (mi0.request_ready) acc[0]++;
    if (mi1.request_ready) acc[1]++;
    if (si.write && si.request_ready) begin
      who = grant[1] ? 1 : 0;
      if ((who == 0 && wq0.size() == 0) || (who == 1 && wq1.size() == 0)) begin
        check("wr_unexpected_beat", 64'(si.address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = (who == 0) ? wq0.pop_front() : wq1.pop_front();
        check("wr_beat_addr_data", {si.address, si.write_data}, {e.addr, e.data});
      end
    end
    if (si.read && si.request_ready) rsp.push_back('{cyc + 5, si.address});
    if (mi0.resp_valid || mi1.resp_valid) begin
      check("resp_one_requester", 64'(mi0.resp_valid & mi1.resp_valid), 64'd0);
      who = mi1.resp_valid ? 1 : 0;
      rcnt[who]++;
      if ((who == 0 && rq0.size() == 0) || (who == 1 && rq1.size() == 0)) begin
        check("rd_unexpected_resp", 64'(who), 64'hFF);
      end else begin
        r = (who == 0) ? rq0.pop_front() : rq1.pop_front();
        check("rd_resp_data", who ? 64'(mi1.read_data) : 64'(mi0.read_data), 64'(r));
      end
    end
  endtask

  // Drive masters and slave just after the rising edge
  task automatic drive();
    logic [31:0] av [2];
    logic [31:0] dv [2];
    bit rv [2], wv [2], bv [2];
    if (abort_seq != abort_taken) begin
      abort_taken = abort_seq;
      for (int n = 0; n < 2; n++) begin act[n] = 1'b0; pulse[n] = 0; end
      wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete(); rsp.delete();
    end
    for (int n = 0; n < 2; n++) begin
      if (act[n] && acc[n] != seen[n]) beat[n]++;
      seen[n] = acc[n];
      if (act[n] && beat[n] > cur[n].cnt) act[n] = 1'b0;
      if (req_seq[n] != taken[n]) begin
        taken[n] = req_seq[n];
        cur[n] = req[n];
        act[n] = 1'b1;
        beat[n] = 0;
        pulse[n] = cur[n].pulses;
        pulse_cyc[n] = cyc;
        for (int b = 0; b <= cur[n].cnt; b++) begin
          if (cur[n].rd) begin
            if (n == 0) rq0.push_back(rdat(cur[n].base + 32'(4 * b)));
            else        rq1.push_back(rdat(cur[n].base + 32'(4 * b)));
          end else begin
            if (n == 0) wq0.push_back('{cur[n].base + 32'(4 * b), wdat(n, cur[n].base, b)});
            else        wq1.push_back('{cur[n].base + 32'(4 * b), wdat(n, cur[n].base, b)});
          end
        end
      end
      bv[n] = act[n] && (pulse[n] > 0);
      if (pulse[n] > 0) pulse[n]--;
      av[n] = act[n] ? cur[n].base + 32'(4 * beat[n]) : 32'h0;
      dv[n] = (act[n] && !cur[n].rd) ? wdat(n, cur[n].base, beat[n]) : 32'h0;
      rv[n] = act[n] && cur[n].rd;
      wv[n] = act[n] && !cur[n].rd;
    end
    mi0.address = av[0]; mi0.write_data = dv[0]; mi0.read = rv[0]; mi0.write = wv[0];
    mi0.begin_burst_transfer = bv[0]; mi0.burst_count = 8'(cur[0].cnt); mi0.byte_en = 4'hF;
    mi1.address = av[1]; mi1.write_data = dv[1]; mi1.read = rv[1]; mi1.write = wv[1];
    mi1.begin_burst_transfer = bv[1]; mi1.burst_count = 8'(cur[1].cnt); mi1.byte_en = 4'hF;
    si.request_ready = tog ? ((cyc % 2) == 1) : 1'b1;
    if (rsp.size() > 0 && rsp[0].due <= cyc) begin
      si.resp_valid = 1'b1;
      si.read_data = rdat(rsp[0].addr);
      void'(rsp.pop_front());
    end else begin
      si.resp_valid = 1'b0;
      si.read_data = 32'h0;
    end
  endtask

  // Bus-functional model process
  initial begin
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; beat[n] = 0; pulse[n] = 0; taken[n] = 0; seen[n] = 0;
      cur[n] = '{1'b0, 32'h0, 0, 0}; pulse_cyc[n] = 0;
    end
    mi0.address = '0; mi0.read = 1'b0; mi0.write = 1'b0; mi0.begin_burst_transfer = 1'b0;
    mi0.burst_count = '0; mi0.byte_en = '0; mi0.write_data = '0;
    mi1.address = '0; mi1.read = 1'b0; mi1.write = 1'b0; mi1.begin_burst_transfer = 1'b0;
    mi1.burst_count = '0; mi1.byte_en = '0; mi1.write_data = '0;
    si.request_ready = 1'b0; si.read_data = '0; si.resp_valid = 1'b0;
    forever begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int n, input bit rd, input logic [31:0] base, input int cnt, input int pulses);
    req[n] = '{rd, base, cnt, pulses};
    req_seq[n]++;
  endtask

  function automatic bit idle_now();
    return (grant == 2'b00) && !act[0] && !act[1] && (wq0.size() == 0) && (wq1.size() == 0) &&
           (rq0.size() == 0) && (rq1.size() == 0) && (rsp.size() == 0);
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = idle_now();
    end
    check({"idle_reached_", tag}, 64'(ok), 64'd1);
  endtask

  initial begin
    int a0, a1, r1, nb, gl, g0;
    bit ok;
    logic [1:0] first_exp, second_exp;
    for (int n = 0; n < 2; n++) begin
      req_seq[n] = 0; acc[n] = 0; gcyc[n] = 0; rcnt[n] = 0;
      req[n] = '{1'b0, 32'h0, 0, 0};
    end
    rest_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_cmd", {si.read, si.write, si.begin_burst_transfer, si.burst_count}, 64'd0);
    check("rst_s_addr_data", {si.address, si.write_data}, 64'd0);
    check("rst_m_ready_resp", {mi0.request_ready, mi1.request_ready, mi0.resp_valid, mi1.resp_valid}, 64'd0);
    rest_n = 1'b1;
    repeat (2) tick();

    // m0 write, 256 beats, ready always high
    a0 = acc[0]; g0 = gcyc[0];
    start(0, 1'b0, 32'h1000_0000, 255, 1);
    wait_idle("w256", 600);
    check("w256_beats", 64'(acc[0] - a0), 64'd256);
    check("w256_grant_cycles", 64'(gcyc[0] - g0), 64'd257);
    check("w256_latency", 64'(last_begin_cyc - pulse_cyc[0]), 64'd2);
    check("w256_burst_count", 64'(last_bc), 64'd255);

    // m1 read of 4 beats; m0 write held off until read data returns
    r1 = rcnt[1]; a0 = acc[0];
    start(1, 1'b1, 32'h2000_0000, 3, 1);
    repeat (3) tick();
    start(0, 1'b0, 32'h3000_0000, 1, 1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (grant == 2'b01);
    end
    check("m0_granted_after_read", 64'(ok), 64'd1);
    check("m1_resps_before_m0", 64'(rcnt[1] - r1), 64'd4);
    wait_idle("rd4", 200);
    check("m0_beats_after_read", 64'(acc[0] - a0), 64'd2);

    // Simultaneous begins
`ifdef AVL_ARB_ROUND_ROBIN_EN
    first_exp = 2'b10; second_exp = 2'b01;
`else
    first_exp = 2'b01; second_exp = 2'b10;
`endif
    gl = glog.size();
    start(0, 1'b0, 32'h3100_0000, 1, 1);
    start(1, 1'b0, 32'h3200_0000, 1, 1);
    wait_idle("dual", 200);
    check("dual_two_bursts", 64'(glog.size() - gl), 64'd2);
    if (glog.size() >= gl + 2) begin
      check("dual_first_owner", 64'(glog[gl]), 64'(first_exp));
      check("dual_second_owner", 64'(glog[gl + 1]), 64'(second_exp));
      check("dual_issue_gap", 64'(bcyc[gl + 1] - bcyc[gl]), 64'd4);
    end

    // 8-beat write with ready toggling every cycle
    tog = 1'b1;
    a0 = acc[0];
    start(0, 1'b0, 32'h4000_0100, 7, 1);
    wait_idle("toggle", 200);
    check("toggle_beats", 64'(acc[0] - a0), 64'd8);
    tog = 1'b0;

    // Repeated begin while still pending yields a single burst
    a0 = acc[0]; nb = nbegin;
    start(0, 1'b0, 32'h4800_0000, 3, 2);
    wait_idle("dup", 200);
    repeat (10) tick();
    check("dup_single_issue", 64'(nbegin - nb), 64'd1);
    check("dup_beats", 64'(acc[0] - a0), 64'd4);

    // Reset in the middle of a long burst, then a fresh m1 read
    a0 = acc[0];
    start(0, 1'b0, 32'h5000_0000, 255, 1);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = (acc[0] - a0 >= 100);
    end
    check("midburst_reached_100", 64'(ok), 64'd1);
    rest_n = 1'b0;
    abort_seq++;
    #1;
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_s_cmd", {si.read, si.write, si.begin_burst_transfer, mi0.request_ready}, 64'd0);
    tick();
    check("midrst_s_addr_data", {si.address, si.write_data}, 64'd0);
    check("midrst_grant_next", 64'(grant), 64'd0);
    tick();
    rest_n = 1'b1;
    tick();
    r1 = rcnt[1]; a1 = acc[1];
    start(1, 1'b1, 32'h6000_0040, 2, 1);
    wait_idle("post_rst", 200);
    check("post_rst_beats", 64'(acc[1] - a1), 64'd3);
    check("post_rst_resps", 64'(rcnt[1] - r1), 64'd3);
    check("post_rst_owner", 64'(glog[glog.size() - 1]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/avl_burst_arbiter.md
AVL_BURST_ARBITER -- requirements
Module: avl_burst_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 256, meaning read beats allowed outstanding at the slave (maximum, and the reset value of the credit counter).
REQ-002 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have ports: rest_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have per requester N in {0,1}: mN_address in 32, mN_read in 1, mN_write in 1, mN_begin_burst_transfer in 1, mN_burst_count in 8 (beats-1), mN_byte_en in 4, mN_write_data in 32.
REQ-005 SHALL have per requester N: mN_request_ready out 1 (beat accepted), mN_read_data out 32, mN_resp_valid out 1.
REQ-006 SHALL have slave side: s_address out 32, s_read out 1, s_write out 1, s_begin_burst_transfer out 1, s_burst_count out 8, s_byte_en out 4, s_write_data out 32.
REQ-007 SHALL have slave side: s_request_ready in 1, s_read_data in 32, s_resp_valid in 1.
REQ-008 SHALL have grant out 2, one-hot current owner ({0,0} when idle), for debug.

Function
REQ-009 SHALL latch pend[N] on a cycle with mN_begin_burst_transfer && (mN_read||mN_write), capturing mN_burst_count and the direction into per-requester registers.
REQ-010 SHALL clear pend[N] in the cycle its grant is issued; a begin pulse arriving while pend[N] is already set SHALL be ignored.
REQ-011 SHALL implement states IDLE, ISSUE, BURST, DRAIN.
REQ-012 IDLE -> ISSUE SHALL occur when any pend is set; the winner is chosen per REQ-026/REQ-027 and recorded in grant.
REQ-013 ISSUE SHALL last exactly one cycle: s_begin_burst_transfer=1, s_burst_count=latched count, then go to BURST.
REQ-014 In ISSUE and BURST, s_address, s_byte_en, s_write_data, s_read and s_write SHALL be combinationally muxed from the owner; from the non-owner these outputs SHALL be 0.
REQ-015 mOwner_request_ready SHALL equal s_request_ready in ISSUE/BURST; the non-owner's request_ready SHALL be 0 at all times.
REQ-016 The beat counter SHALL increment on each s_request_ready in ISSUE/BURST.
REQ-017 When the beat count reaches burst_count+1, a write burst SHALL go to IDLE and a read burst SHALL go to DRAIN; burst_count=255 means 256 beats.
REQ-018 The read credit counter SHALL decrement per accepted read beat and increment per s_resp_valid; a grant of a read burst larger than the available credit SHALL be deferred.
REQ-019 Responses (s_resp_valid, s_read_data) SHALL be routed to the requester that issued the current read burst; the other requester's resp_valid SHALL be 0.
REQ-020 DRAIN SHALL return to IDLE when all beats of the burst have returned; no new grant SHALL be issued before then.
REQ-021 Latency from begin pulse to s_begin_burst_transfer SHALL be 2 cycles when the slave is idle.
REQ-022 Simultaneous begin pulses SHALL both be latched; the loser SHALL be issued directly after the winner completes (IDLE for 1 cycle).
REQ-023 The beat counter is 9 bits and SHALL NOT wrap within a burst.

Reset
REQ-024 On rest_n=0: state=IDLE, pend=0, grant=0, beat counter=0, credit=MAX_OUTSTANDING, last-winner=1.
REQ-025 All outputs SHALL be 0 during reset; reset mid-burst SHALL abandon the burst with no residual grant.

Configuration
REQ-026 With AVL_ARB_ROUND_ROBIN_EN defined, the requester not granted last SHALL win a simultaneous contest.
REQ-027 Without AVL_ARB_ROUND_ROBIN_EN, m0 SHALL always win (fixed priority, for the camera write path).

Verification
REQ-028 m0 write pulse, count=255, s_request_ready=1 -> grant=01 for 257 cycles incl. ISSUE, 256 m0_request_ready beats, then IDLE.
REQ-029 m1 read, count=3, responses returned 5 cycles later -> 4 beats on m1_resp_valid; m0 not granted until the 4th response.
REQ-030 Both pulse the same cycle, round-robin on, last-winner=0 -> m1 first, then m0; macro off -> m0 first.
REQ-031 s_request_ready toggling 50% during a count=7 write -> exactly 8 beats accepted; s_address follows m0_address.
REQ-032 rest_n low at beat 100 of 256 -> all outputs 0 next cycle, grant=00; new m1 pulse after release is served normally.
REQ-033 Second m0 pulse while pend[0] is set -> ignored; only one burst is issued.
